// File: rtl/morse_keyer_tx.sv
// rtl/morse_keyer_tx.sv - Morse code keyer: one character per handshake, ITU unit timing
`timescale 1ns/1ps
module morse_keyer_tx #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] DOT_LEN  = CW'(UNIT_CYCLES);
  localparam logic [CW-1:0] DASH_LEN = CW'(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    SPACE = 3'd2,
    GAP   = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    pat_q, pat_d;
  logic [2:0]    rem_q, rem_d;
  logic          key_out_q, key_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          char_ready_q, char_ready_d;

  logic [2:0]    rom_len;
  logic [4:0]    rom_raw;
  logic [4:0]    rom_pat;
  logic          rom_valid;

  // Character ROM: length plus right-aligned elements (1 = dash), left-aligned so bit 4 goes first
  always_comb begin
    rom_len = 3'd1;
    rom_raw = 5'b00000;
    case (char_in)
      6'd0:  {rom_len, rom_raw} = {3'd2, 5'b00001}; // A .-
      6'd1:  {rom_len, rom_raw} = {3'd4, 5'b01000}; // B -...
      6'd2:  {rom_len, rom_raw} = {3'd4, 5'b01010}; // C -.-.
      6'd3:  {rom_len, rom_raw} = {3'd3, 5'b00100}; // D -..
      6'd4:  {rom_len, rom_raw} = {3'd1, 5'b00000}; // E .
      6'd5:  {rom_len, rom_raw} = {3'd4, 5'b00010}; // F ..-.
      6'd6:  {rom_len, rom_raw} = {3'd3, 5'b00110}; // G --.
      6'd7:  {rom_len, rom_raw} = {3'd4, 5'b00000}; // H ....
      6'd8:  {rom_len, rom_raw} = {3'd2, 5'b00000}; // I ..
      6'd9:  {rom_len, rom_raw} = {3'd4, 5'b00111}; // J .---
      6'd10: {rom_len, rom_raw} = {3'd3, 5'b00101}; // K -.-
      6'd11: {rom_len, rom_raw} = {3'd4, 5'b00100}; // L .-..
      6'd12: {rom_len, rom_raw} = {3'd2, 5'b00011}; // M --
      6'd13: {rom_len, rom_raw} = {3'd2, 5'b00010}; // N -.
      6'd14: {rom_len, rom_raw} = {3'd3, 5'b00111}; // O ---
      6'd15: {rom_len, rom_raw} = {3'd4, 5'b00110}; // P .--.
      6'd16: {rom_len, rom_raw} = {3'd4, 5'b01101}; // Q --.-
      6'd17: {rom_len, rom_raw} = {3'd3, 5'b00010}; // R .-.
      6'd18: {rom_len, rom_raw} = {3'd3, 5'b00000}; // S ...
      6'd19: {rom_len, rom_raw} = {3'd1, 5'b00001}; // T -
      6'd20: {rom_len, rom_raw} = {3'd3, 5'b00001}; // U ..-
      6'd21: {rom_len, rom_raw} = {3'd4, 5'b00001}; // V ...-
      6'd22: {rom_len, rom_raw} = {3'd3, 5'b00011}; // W .--
      6'd23: {rom_len, rom_raw} = {3'd4, 5'b01001}; // X -..-
      6'd24: {rom_len, rom_raw} = {3'd4, 5'b01011}; // Y -.--
      6'd25: {rom_len, rom_raw} = {3'd4, 5'b01100}; // Z --..
      6'd26: {rom_len, rom_raw} = {3'd5, 5'b11111}; // 0
      6'd27: {rom_len, rom_raw} = {3'd5, 5'b01111}; // 1
      6'd28: {rom_len, rom_raw} = {3'd5, 5'b00111}; // 2
      6'd29: {rom_len, rom_raw} = {3'd5, 5'b00011}; // 3
      6'd30: {rom_len, rom_raw} = {3'd5, 5'b00001}; // 4
      6'd31: {rom_len, rom_raw} = {3'd5, 5'b00000}; // 5
      6'd32: {rom_len, rom_raw} = {3'd5, 5'b10000}; // 6
      6'd33: {rom_len, rom_raw} = {3'd5, 5'b11000}; // 7
      6'd34: {rom_len, rom_raw} = {3'd5, 5'b11100}; // 8
      6'd35: {rom_len, rom_raw} = {3'd5, 5'b11110}; // 9
      default: {rom_len, rom_raw} = {3'd1, 5'b00000};
    endcase
  end

  assign rom_valid = (char_in < 6'd36);
  assign rom_pat   = rom_raw << (3'd5 - rom_len);

  // State, element shift register and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pat_q        <= '0;
      rem_q        <= '0;
      key_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      char_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pat_q        <= pat_d;
      rem_q        <= rem_d;
      key_out_q    <= key_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      char_ready_q <= char_ready_d;
    end
  end

  // Next state: cnt_q holds the cycles left in the current state, including this one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (char_valid) begin
          if (rom_valid) begin
            state_d = MARK;
            pat_d   = rom_pat;
            rem_d   = rom_len;
            cnt_d   = rom_pat[4] ? DASH_LEN : DOT_LEN;
          end else begin
            state_d = ERR;
          end
        end
      end
      MARK: begin
        if (cnt_q == CNT_ONE) begin
          if (rem_q > 3'd1) begin
            state_d = SPACE;
            cnt_d   = DOT_LEN;
          end else begin
            state_d = GAP;
            cnt_d   = DASH_LEN;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SPACE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = MARK;
          pat_d   = {pat_q[3:0], 1'b0};
          rem_d   = rem_q - 3'd1;
          cnt_d   = pat_q[3] ? DASH_LEN : DOT_LEN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    key_out_d    = (state_d == MARK);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == GAP) && (cnt_d == CNT_ONE);
    err_d        = (state_d == ERR);
    char_ready_d = (state_d == IDLE);
  end

  assign key_out    = key_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign char_ready = char_ready_q;

endmodule
